// File: rtl/radix4_booth_mac_seq.sv
// Iterative radix-4 Booth multiply-accumulate: one Booth digit per cycle,
// valid/ready on both sides, optional signed accumulator with sticky overflow.
module radix4_booth_mac_seq #(
  parameter int N         = 8,
  parameter int ACC_GUARD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             a,
  input  logic [N-1:0]             b,
  input  logic                     signed_mode,
  input  logic                     acc_en,
  input  logic                     acc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*N-1:0]           prod,
  output logic [2*N+ACC_GUARD-1:0] acc,
  output logic                     acc_ovf,
  output logic                     busy
);

  localparam int AW = 2*N + ACC_GUARD;
  localparam int PW = 2*N + 2;
  localparam int EW = N + 2;
  localparam int CW = $clog2(N/2 + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic signed [EW-1:0] a_q;
  logic [EW:0]          b_sh_q;
  logic                 signed_q;
  logic                 acc_en_q;
  logic                 acc_clr_q;
  logic [PW-1:0]        psum_q;
  logic [CW-1:0]        cnt_q;
  logic [2*N-1:0]       prod_q;
  logic [AW-1:0]        acc_q;
  logic                 ovf_q;

  logic                 accept;
  logic [EW-1:0]        a_ext_d;
  logic [EW-1:0]        b_ext_d;
  logic signed [PW-1:0] a_wide;
  logic signed [PW-1:0] term;
  logic [CW:0]          shamt;
  logic [PW-1:0]        psum_d;
  logic                 last_digit;
  logic [2*N-1:0]       prod_d;
  logic [AW-1:0]        prod_ext;
  logic [AW-1:0]        acc_sum;
  logic                 add_ovf;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign prod      = prod_q;
  assign acc       = acc_q;
  assign acc_ovf   = ovf_q;

  // Two extra bits let unsigned operands use the same signed Booth recoding.
  assign a_ext_d = signed_mode ? {{2{a[N-1]}}, a} : {2'b00, a};
  assign b_ext_d = signed_mode ? {{2{b[N-1]}}, b} : {2'b00, b};

  // The multiplier shifts right two bits per digit, so the current
  // triplet {b[2k+1], b[2k], b[2k-1]} always sits in the bottom three bits.
  assign a_wide = PW'(a_q);

  always_comb begin
    term = '0;
    case (b_sh_q[2:0])
      3'b001, 3'b010: term = a_wide;
      3'b011:         term = a_wide <<< 1;
      3'b100:         term = -(a_wide <<< 1);
      3'b101, 3'b110: term = -a_wide;
      default:        term = '0;
    endcase
  end

  assign shamt      = {cnt_q, 1'b0};
  assign psum_d     = psum_q + (term << shamt);
  assign last_digit = (cnt_q == (signed_q ? CW'(N/2 - 1) : CW'(N/2)));
  assign prod_d     = psum_d[2*N-1:0];

  assign prod_ext = signed_q ? AW'(signed'(prod_d)) : AW'(prod_d);
  assign acc_sum  = acc_q + prod_ext;
  assign add_ovf  = (acc_q[AW-1] == prod_ext[AW-1]) && (acc_sum[AW-1] != acc_q[AW-1]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_sh_q    <= '0;
      signed_q  <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      psum_q    <= '0;
      cnt_q     <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            a_q       <= a_ext_d;
            b_sh_q    <= {b_ext_d, 1'b0};
            signed_q  <= signed_mode;
            acc_en_q  <= acc_en;
            acc_clr_q <= acc_clr;
            psum_q    <= '0;
            cnt_q     <= '0;
            state_q   <= RUN;
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          psum_q <= psum_d;
          b_sh_q <= b_sh_q >> 2;
          cnt_q  <= cnt_q + CW'(1);
          if (last_digit) begin
            prod_q <= prod_d;
            if (acc_en_q) begin
              if (acc_clr_q) begin
                acc_q <= prod_ext;
                ovf_q <= 1'b0;
              end else begin
                acc_q <= acc_sum;
                ovf_q <= ovf_q | add_ovf;
              end
            end
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
